// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the two-requester ALU sharing controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_share_ctrl_pkg;

  localparam int DATA_W = 64;

  // ALU control codes; any other code is treated as illegal by the controller.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ALU_64_bit.sv
// Purpose: combinational 64-bit ALU (AND, OR, ADD, SUB, NOR), modulo 2^64.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows inputs.
// Ports: a_i/b_i operands, alu_ctrl_i op code, result_o result, zero_o result==0.
module ALU_64_bit
  import alu_share_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        alu_ctrl_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_ADD:  result_o = a_i + b_i;  // carry out dropped
      OP_SUB:  result_o = a_i - b_i;  // borrow dropped
      OP_NOR:  result_o = ~(a_i | b_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Purpose: arbitrates two requesters onto one shared 64-bit ALU (round-robin on ties).
// Latency: accept -> one EXEC cycle -> result held in RESP; 3 cycles/op when resp ready is high.
// Backpressure: no request accepted until the owner's resp handshake returns the FSM to IDLE.
// Ports: clk/rst_n; reqN_valid/ready/a/b/op request side; respN_valid/ready handshake;
//        resp_result/resp_zero/resp_err shared registered result bus.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              req1_ready,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic              any_vld;
  logic              gnt_idx;
  logic              op_legal;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // On a tie the requester that was not granted last wins; otherwise the lone valid one.
  assign any_vld = req0_valid | req1_valid;
  assign gnt_idx = (req0_valid & req1_valid) ? ~last_q : req1_valid;

  assign op_legal = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                    (op_q == OP_SUB) || (op_q == OP_NOR);

  ALU_64_bit u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .alu_ctrl_i (op_q),
    .result_o   (alu_result),
    .zero_o     (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = any_vld & ~gnt_idx;
        req1_ready = any_vld & gnt_idx;
        // Ready is only raised for a valid requester, so any_vld means a handshake.
        if (any_vld) begin
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          a_d     = gnt_idx ? req1_a  : req0_a;
          b_d     = gnt_idx ? req1_b  : req0_b;
          op_d    = gnt_idx ? req1_op : req0_op;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_legal) begin
          result_d = alu_result;
          zero_d   = alu_zero;
          err_d    = 1'b0;
        end else begin
          result_d = '0;
          zero_d   = 1'b1;
          err_d    = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        // The non-owner's ready is deliberately ignored.
        if (owner_q ? resp1_ready : resp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= RR_INIT;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Purpose: self-checking bench for alu_share_ctrl against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: exercises resp ready held low for several cycles.
module tb_alu_share_ctrl;

  localparam logic RR_INIT = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [63:0] resp_result;
  logic        resp_zero, resp_err;

  int n_chk = 0;
  int n_err = 0;
  bit last_gnt;  // model: index of the requester granted most recently

  always #5 clk = ~clk;

  alu_share_ctrl #(.RR_INIT(RR_INIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {err, zero, result} from the op-code table.
  function automatic logic [65:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1100: r = ~(a | b);
      default: begin r = 64'd0; e = 1'b1; end
    endcase
    return {e, (r == 64'd0), r};
  endfunction

  task automatic clear_inputs();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  // One full transaction: present, accept, EXEC, RESP held for bp cycles, handshake.
  task automatic issue(input bit v0, input logic [3:0] op0, input logic [63:0] a0,
                       input logic [63:0] b0, input bit v1, input logic [3:0] op1,
                       input logic [63:0] a1, input logic [63:0] b1, input int bp);
    bit          w;
    logic [65:0] e;
    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    w = (v0 && v1) ? ~last_gnt : v1;
    e = w ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
    #1;
    chk("idle_rdy0", 64'(req0_ready), 64'(!w));
    chk("idle_rdy1", 64'(req1_ready), 64'(w));
    last_gnt = w;
    // EXEC: winner withdraws, loser keeps its request pending.
    @(negedge clk);
    if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk("exec_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
    chk("exec_rvld", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    @(negedge clk);
    for (int c = 0; c <= bp; c++) begin
      if (c > 0) @(negedge clk);
      if (w) begin
        resp1_ready = (c == bp);
        resp0_ready = 1'($urandom_range(0, 1));
      end else begin
        resp0_ready = (c == bp);
        resp1_ready = 1'($urandom_range(0, 1));
      end
      #1;
      chk("resp_vld0", 64'(resp0_valid), 64'(!w));
      chk("resp_vld1", 64'(resp1_valid), 64'(w));
      chk("resp_result", resp_result, e[63:0]);
      chk("resp_zero", 64'(resp_zero), 64'(e[64]));
      chk("resp_err", 64'(resp_err), 64'(e[65]));
      chk("resp_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
    end
    @(negedge clk);
    // Drop any still-pending loser request before IDLE can accept it.
    clear_inputs();
    #1;
    chk("done_rvld", {62'd0, resp1_valid, resp0_valid}, 64'd0);
  endtask

  localparam logic [3:0] LEGAL [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0]  op0, op1;
    logic [63:0] a0, b0, a1, b1;
    bit          v0, v1;

    // Reset state, and grant logic follows the valids while in reset.
    last_gnt = RR_INIT;
    #2;
    chk("rst_rvld", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    chk("rst_result", resp_result, 64'd0);
    chk("rst_zero", 64'(resp_zero), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_rdy_none", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b1;
    #1;
    chk("rst_rdy_single", {62'd0, req1_ready, req0_ready}, 64'd1);
    req1_valid = 1'b1;
    #1;
    chk("rst_rdy_tie", {62'd0, req1_ready, req0_ready}, 64'd2);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie from reset: req1 first, then req0.
    issue(1, 4'b0110, 64'd7, 64'd7, 1, 4'b0001, 64'hF0, 64'h0F, 0);
    issue(1, 4'b0110, 64'd7, 64'd7, 0, 4'b0000, 64'd0, 64'd0, 0);
    // Single request.
    issue(1, 4'b0010, 64'd5, 64'd3, 0, 4'b0000, 64'd0, 64'd0, 0);
    // Wrap-around.
    issue(1, 4'b0010, {64{1'b1}}, 64'd1, 0, 4'b0000, 64'd0, 64'd0, 0);
    issue(0, 4'b0000, 64'd0, 64'd0, 1, 4'b0110, 64'd0, 64'd1, 0);
    // Backpressure for 5 cycles.
    issue(1, 4'b1100, 64'h1234, 64'h00FF, 0, 4'b0000, 64'd0, 64'd0, 5);
    // Illegal op.
    issue(1, 4'b0101, 64'hAA, 64'hAA, 0, 4'b0000, 64'd0, 64'd0, 0);
    // Non-zero result in the register before the reset test.
    issue(1, 4'b0010, 64'd5, 64'd3, 0, 4'b0000, 64'd0, 64'd0, 0);

    // Reset during EXEC.
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 64'd100; req1_b = 64'd1;
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rexec_rvld", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    chk("rexec_result", resp_result, 64'd0);
    chk("rexec_zero", 64'(resp_zero), 64'd0);
    chk("rexec_err", 64'(resp_err), 64'd0);
    last_gnt = RR_INIT;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rexec_no_resp", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    end
    issue(1, 4'b0001, 64'h0F00, 64'h00F0, 0, 4'b0000, 64'd0, 64'd0, 0);
    // Ties alternate after a non-tie grant.
    issue(1, 4'b0010, 64'd1, 64'd2, 1, 4'b0010, 64'd3, 64'd4, 1);
    issue(1, 4'b0000, 64'hFF, 64'h0F, 1, 4'b1100, 64'd0, 64'd0, 0);

    // Randomised traffic.
    for (int it = 0; it < 60; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      op0 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : LEGAL[$urandom_range(0, 4)];
      op1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : LEGAL[$urandom_range(0, 4)];
      a0 = rand_operand(); b0 = rand_operand();
      a1 = rand_operand(); b1 = rand_operand();
      issue(v0, op0, a0, b0, v1, op1, a1, b1, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
